charvram_port_arbiter: RTL and testbench

Sole owner of the character VRAM write port, shared between two requesters. CPU stores to the 0xD address region are buffered in a small posted-write FIFO. PS2 keyboard bytes are echoed to the screen at a hardware cursor. A fixed-priority arbiter with a starvation guard issues at most one registered VRAM write per cycle. The block also returns a status word on CPU reads of the 0xD region.

---
 rtl/charvram_port_arbiter.sv | 113 +++++++++++
 tb/tb_charvram_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/charvram_port_arbiter.sv
// charvram_port_arbiter: shares the character VRAM write port between a CPU posted-write FIFO and PS2 key echo
module charvram_port_arbiter #(
    parameter int DEPTH_LOG2 = 2,
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    input  logic [31:0] cpu_data2bus,
    input  logic        mem_w,
    output logic        cpu_wr_stall,
    output logic [31:0] cpu_data4bus,
    input  logic        ps2_ready,
    input  logic [7:0]  ps2_data,
    output logic        ps2_ack,
    output logic [12:0] addr_2_charvram,
    output logic [7:0]  data_2_charvram,
    output logic        wea_2_charvram,
    output logic [12:0] cursor_pos
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [13:0] CELLS_W = 14'(COLS * ROWS);
    localparam logic [13:0] COLS_W = 14'(COLS);

    logic [21:0] fifo_mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr, rptr, count;
    logic sel, empty, full, push, key_pending, grant_key, grant_cpu, wr_en;
    logic [7:0] key_byte, wr_data;
    logic [WW-1:0] wait_cnt;
    logic [21:0] entry;
    logic [13:0] cur_w, row_next;
    logic [12:0] cursor_inc, nxt_cursor, wr_addr;
    logic unused;

    assign unused = ^{addr_bus[27:0], cpu_data2bus[30:21]};
    assign sel = addr_bus[31:28] == 4'hd;
    assign count = wptr - rptr;
    assign empty = count == '0;
    assign full = count[DEPTH_LOG2];
    assign push = sel && mem_w && !full;
    assign cpu_wr_stall = sel && mem_w && full;
    assign cpu_data4bus = (sel && !mem_w) ? {10'b0, key_pending, full, empty, 6'b0, cursor_pos} : '0;
    assign entry = fifo_mem[rptr[DEPTH_LOG2-1:0]];
    assign grant_key = key_pending && (empty || wait_cnt >= WW'(MAX_WAIT));
    assign grant_cpu = !grant_key && !empty;

    // Entry layout: {cursor-set flag, cell address, character}
    always_ff @(posedge clk)
        if (push) fifo_mem[wptr[DEPTH_LOG2-1:0]] <= {cpu_data2bus[31], cpu_data2bus[20:8], cpu_data2bus[7:0]};

    always_comb begin
        cur_w = {1'b0, cursor_pos};
        row_next = (cur_w / COLS_W + 14'd1) * COLS_W;
        cursor_inc = (cur_w + 14'd1 == CELLS_W) ? '0 : cursor_pos + 13'd1;
        nxt_cursor = cursor_pos;
        wr_en = 1'b0;
        wr_addr = addr_2_charvram;
        wr_data = data_2_charvram;
        if (grant_cpu) begin
            if (entry[21]) nxt_cursor = ({1'b0, entry[20:8]} < CELLS_W) ? entry[20:8] : '0;
            else begin
                wr_en = 1'b1;
                wr_addr = entry[20:8];
                wr_data = entry[7:0];
            end
        end else if (grant_key) begin
            if (key_byte >= 8'h20 && key_byte <= 8'h7e) begin
                wr_en = 1'b1;
                wr_addr = cursor_pos;
                wr_data = key_byte;
                nxt_cursor = cursor_inc;
            end else if (key_byte == 8'h0d) nxt_cursor = (row_next >= CELLS_W) ? '0 : row_next[12:0];
            else if (key_byte == 8'h08 && cursor_pos != '0) begin
                // Backspace blanks the cell it moves onto
                nxt_cursor = cursor_pos - 13'd1;
                wr_en = 1'b1;
                wr_addr = cursor_pos - 13'd1;
                wr_data = 8'h20;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            key_pending <= 1'b0;
            key_byte <= '0;
            ps2_ack <= 1'b0;
            wait_cnt <= '0;
            cursor_pos <= '0;
            wea_2_charvram <= 1'b0;
            addr_2_charvram <= '0;
            data_2_charvram <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (grant_cpu) rptr <= rptr + 1'b1;
            ps2_ack <= ps2_ready && !key_pending;
            if (ps2_ready && !key_pending) begin
                key_pending <= 1'b1;
                key_byte <= ps2_data;
            end else if (grant_key) key_pending <= 1'b0;
            if (grant_key) wait_cnt <= '0;
            else if (grant_cpu && key_pending && wait_cnt < WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            cursor_pos <= nxt_cursor;
            wea_2_charvram <= wr_en;
            addr_2_charvram <= wr_addr;
            data_2_charvram <= wr_data;
        end
endmodule

// File: tb/tb_charvram_port_arbiter.sv
// tb_charvram_port_arbiter: directed stimulus with a write scoreboard drained by a negedge monitor
module tb_charvram_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] addr_bus = '0, cpu_data2bus = '0;
    logic mem_w = 1'b0, ps2_ready = 1'b0;
    logic [7:0] ps2_data = '0;
    logic cpu_wr_stall, ps2_ack, wea_2_charvram;
    logic [31:0] cpu_data4bus;
    logic [12:0] addr_2_charvram, cursor_pos;
    logic [7:0] data_2_charvram;
    int checks = 0, failures = 0;
    logic [20:0] exp_q [$];
    logic [20:0] mon_e;

    always #5 clk = ~clk;

    charvram_port_arbiter dut (
        .clk(clk), .rst(rst), .addr_bus(addr_bus), .cpu_data2bus(cpu_data2bus), .mem_w(mem_w),
        .cpu_wr_stall(cpu_wr_stall), .cpu_data4bus(cpu_data4bus), .ps2_ready(ps2_ready),
        .ps2_data(ps2_data), .ps2_ack(ps2_ack), .addr_2_charvram(addr_2_charvram),
        .data_2_charvram(data_2_charvram), .wea_2_charvram(wea_2_charvram), .cursor_pos(cursor_pos)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wdat(input logic [12:0] a, input logic [7:0] c, input logic f);
        return {f, 10'b0, a, c};
    endfunction

    task automatic expect_wr(input logic [12:0] a, input logic [7:0] c);
        exp_q.push_back({a, c});
    endtask

    task automatic cpu_wr(input logic [31:0] d);
        addr_bus = 32'hD000_0000;
        cpu_data2bus = d;
        mem_w = 1'b1;
        tick();
        mem_w = 1'b0;
        addr_bus = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic status(input string name, input logic [31:0] exp);
        addr_bus = 32'hD000_0000;
        mem_w = 1'b0;
        #1;
        chk(name, cpu_data4bus, exp);
        addr_bus = '0;
    endtask

    task automatic send_key(input logic [7:0] b);
        ps2_data = b;
        ps2_ready = 1'b1;
        tick();
        chk("key_ack", 32'(ps2_ack), 1);
        ps2_ready = 1'b0;
        repeat (4) tick();
    endtask

    // Every VRAM write must match the head of the expected queue
    always @(negedge clk)
        if (!rst && wea_2_charvram) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write", addr_2_charvram, data_2_charvram);
            end else begin
                mon_e = exp_q.pop_front();
                if ({addr_2_charvram, data_2_charvram} !== mon_e) begin
                    failures++;
                    $display("FAIL vram_write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                             addr_2_charvram, data_2_charvram, mon_e[20:8], mon_e[7:0]);
                end
            end
        end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int n_acc, ack_cnt;
        logic stalled;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wea", 32'(wea_2_charvram), 0);
        chk("rst_addr", 32'(addr_2_charvram), 0);
        chk("rst_data", 32'(data_2_charvram), 0);
        chk("rst_cursor", 32'(cursor_pos), 0);
        chk("rst_ack", 32'(ps2_ack), 0);
        chk("rst_stall", 32'(cpu_wr_stall), 0);
        chk("rst_status", cpu_data4bus, 0);
        rst = 1'b0;
        tick();
        status("status_after_reset", 32'h0008_0000);

        expect_wr(13'h123, 8'h41);
        cpu_wr(32'h0001_2341);
        chk("lat_early_wea", 32'(wea_2_charvram), 0);
        tick();
        chk("lat_wea", 32'(wea_2_charvram), 1);
        chk("lat_addr", 32'(addr_2_charvram), 32'h123);
        chk("lat_data", 32'(data_2_charvram), 32'h41);
        tick();
        chk("wea_one_cycle", 32'(wea_2_charvram), 0);
        drain("drain_single");

        // Forced key grants (discarded byte 0x01) are the only cycles without a pop
        ps2_data = 8'h01;
        ps2_ready = 1'b1;
        addr_bus = 32'hD000_0000;
        mem_w = 1'b1;
        n_acc = 0;
        stalled = 1'b0;
        for (int i = 0; i < 40 && !stalled; i++) begin
            cpu_data2bus = wdat(13'(13'h200 + i), 8'(i), 1'b0);
            #1;
            if (cpu_wr_stall) stalled = 1'b1;
            else begin
                expect_wr(13'(13'h200 + i), 8'(i));
                n_acc++;
            end
            tick();
        end
        mem_w = 1'b0;
        addr_bus = '0;
        ps2_ready = 1'b0;
        chk("stall_seen", 32'(stalled), 1);
        chk("accepted_before_stall", n_acc, 18);
        drain("drain_fifo_full");
        chk("cursor_after_full", 32'(cursor_pos), 0);

        for (int i = 0; i < 4; i++) expect_wr(13'(13'h300 + i), 8'(8'h50 + i));
        expect_wr(13'd0, 8'h41);
        for (int i = 4; i < 6; i++) expect_wr(13'(13'h300 + i), 8'(8'h50 + i));
        for (int i = 0; i < 6; i++) begin
            addr_bus = 32'hD000_0000;
            mem_w = 1'b1;
            cpu_data2bus = wdat(13'(13'h300 + i), 8'(8'h50 + i), 1'b0);
            ps2_data = 8'h41;
            ps2_ready = (i == 0);
            tick();
        end
        mem_w = 1'b0;
        addr_bus = '0;
        ps2_ready = 1'b0;
        drain("drain_starvation");
        chk("cursor_after_starve", 32'(cursor_pos), 1);

        cpu_wr(wdat(13'd2390, 8'h00, 1'b1));
        tick();
        chk("cursor_set_2390", 32'(cursor_pos), 2390);
        send_key(8'h0d);
        chk("cr_last_row_wraps", 32'(cursor_pos), 0);
        cpu_wr(wdat(13'd2399, 8'h00, 1'b1));
        tick();
        chk("cursor_set_2399", 32'(cursor_pos), 2399);
        expect_wr(13'd2399, 8'h42);
        send_key(8'h42);
        chk("key_cursor_wrap", 32'(cursor_pos), 0);
        send_key(8'h08);
        chk("bs_at_zero", 32'(cursor_pos), 0);
        cpu_wr(wdat(13'd85, 8'h00, 1'b1));
        tick();
        chk("cursor_set_85", 32'(cursor_pos), 85);
        cpu_wr(wdat(13'd3000, 8'h00, 1'b1));
        tick();
        chk("cursor_set_oob", 32'(cursor_pos), 0);
        cpu_wr(wdat(13'd85, 8'h00, 1'b1));
        tick();
        send_key(8'h0d);
        chk("cr_next_row", 32'(cursor_pos), 160);
        expect_wr(13'd159, 8'h20);
        send_key(8'h08);
        chk("bs_cursor", 32'(cursor_pos), 159);
        drain("drain_echo");

        // ps2_ready held 3 cycles while CPU traffic keeps the key pending
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                addr_bus = 32'hD000_0000;
                mem_w = 1'b1;
                cpu_data2bus = wdat(13'(13'h400 + i), 8'(8'h70 + i), 1'b0);
                expect_wr(13'(13'h400 + i), 8'(8'h70 + i));
            end else begin
                addr_bus = '0;
                mem_w = 1'b0;
            end
            ps2_data = 8'h01;
            ps2_ready = (i < 3);
            tick();
            if (ps2_ack) ack_cnt++;
        end
        chk("ack_single", ack_cnt, 1);
        status("status_after_handshake", 32'h0008_009F);
        drain("drain_handshake");

        expect_wr(13'h555, 8'h5a);
        cpu_wr(wdat(13'h555, 8'h5a, 1'b0));
        cpu_wr(wdat(13'h556, 8'h5b, 1'b0));
        chk("pre_rst_wea", 32'(wea_2_charvram), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wea", 32'(wea_2_charvram), 0);
        chk("mid_rst_addr", 32'(addr_2_charvram), 0);
        chk("mid_rst_data", 32'(data_2_charvram), 0);
        chk("mid_rst_cursor", 32'(cursor_pos), 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        status("status_after_mid_reset", 32'h0008_0000);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
